info_packer: RTL and testbench

INFO_PACKER -- requirements
Module: info_packer

---
 rtl/template_pkg.sv | 17 +
 rtl/info_packer_if.sv | 26 ++
 rtl/info_packer_addr_fifo.sv | 48 ++++
 rtl/info_packer.sv | 97 +++++++++
 tb/tb_info_packer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/template_pkg.sv
// rtl/template_pkg.sv - shared types and widths for the info packer
package template_pkg;

    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]      vld;
        logic [1:0][7:0] addr;
    } info_t;

endpackage

// File: rtl/info_packer_if.sv
// rtl/info_packer_if.sv - upstream address and downstream beat bundle
interface info_packer_if #(
    parameter int CNT_WIDTH = template_pkg::CNT_WIDTH
);
    import template_pkg::*;

    logic                 en_i;
    logic                 in_vld_i;
    logic [7:0]           in_addr_i;
    logic                 in_rdy_o;
    info_t                info_o;
    logic                 info_rdy_i;
    logic [CNT_WIDTH-1:0] beat_cnt_o;
    logic                 end_cnt_o;

    modport master (
        output en_i, in_vld_i, in_addr_i, info_rdy_i,
        input  in_rdy_o, info_o, beat_cnt_o, end_cnt_o
    );

    modport slave (
        input  en_i, in_vld_i, in_addr_i, info_rdy_i,
        output in_rdy_o, info_o, beat_cnt_o, end_cnt_o
    );

endinterface

// File: rtl/info_packer_addr_fifo.sv
// rtl/info_packer_addr_fifo.sv - 8-bit address FIFO with single push and 0/1/2 pop per cycle
module addr_fifo #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic [1:0]  pop_n,
    output logic [7:0]  head0,
    output logic [7:0]  head1,
    output logic [AW:0] count,
    output logic        full
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;

    // Full refuses the push even if a pop frees space this cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign head0   = mem[rd_ptr];
    assign head1   = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(pop_n);
        end
    end

endmodule

// File: rtl/info_packer.sv
// rtl/info_packer.sv - packs buffered addresses into two-lane beats and counts accepted beats per run
module info_packer
    import template_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = template_pkg::CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    info_packer_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t               state;
    logic [AW:0]          occ;
    logic                 full;
    logic [7:0]           head0;
    logic [7:0]           head1;
    logic [1:0]           pop_n;
    logic                 accept;
    info_t                info;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 end_cnt;

    addr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_vld_i),
        .din   (bus.in_addr_i),
        .pop_n (pop_n),
        .head0 (head0),
        .head1 (head1),
        .count (occ),
        .full  (full)
    );

    always_comb begin
        info = '0;
        if (state == RUN) begin
            if (occ != '0) begin
                info.vld[0]  = 1'b1;
                info.addr[0] = head0;
            end
            if (occ >= (AW+1)'(2)) begin
                info.vld[1]  = 1'b1;
                info.addr[1] = head1;
            end
        end
    end

    assign accept = bus.info_rdy_i & (|info.vld);
    assign pop_n  = !accept ? 2'd0 : (info.vld[1] ? 2'd2 : 2'd1);

    // The terminal beat sends the counter back to zero through DONE instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            end_cnt  <= 1'b0;
        end else begin
            end_cnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept && (beat_cnt == '1)) begin
                        state    <= DONE;
                        beat_cnt <= '0;
                        end_cnt  <= 1'b1;
                    end else begin
                        if (accept) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (!bus.en_i) begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy_o   = ~full;
    assign bus.info_o     = info;
    assign bus.beat_cnt_o = beat_cnt;
    assign bus.end_cnt_o  = end_cnt;

endmodule

// File: tb/tb_info_packer.sv
// tb/tb_info_packer.sv - directed self-checking bench for info_packer
module tb_info_packer;
    import template_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    info_packer_if #(.CNT_WIDTH(4)) bus ();

    info_packer #(.FIFO_DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic info_t mk(input logic [1:0] v, input logic [7:0] a1, input logic [7:0] a0);
        info_t r;
        r.vld     = v;
        r.addr[1] = a1;
        r.addr[0] = a0;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en_i       = 1'b0;
        bus.in_vld_i   = 1'b0;
        bus.in_addr_i  = 8'h00;
        bus.info_rdy_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (bus.in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b want 1", bus.in_rdy_o); end
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL reset_info got %h want 0", bus.info_o); end
        n_cmp++; if (bus.beat_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_beat got %0d want 0", bus.beat_cnt_o); end
        n_cmp++; if (bus.end_cnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_end got %b want 0", bus.end_cnt_o); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_dual_pop();
        do_reset();
        bus.in_vld_i = 1'b1; bus.in_addr_i = 8'hA1; step();
        bus.in_addr_i = 8'hB2; step();
        bus.in_vld_i = 1'b0; bus.en_i = 1'b1; bus.info_rdy_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL dual_idle_info got %h want 0", bus.info_o); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== mk(2'b11, 8'hB2, 8'hA1)) begin n_fail++; $display("FAIL dual_beat got %h want %h", bus.info_o, mk(2'b11, 8'hB2, 8'hA1)); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.beat_cnt_o !== 4'd1) begin n_fail++; $display("FAIL dual_beat_cnt got %0d want 1", bus.beat_cnt_o); end
        n_cmp++; if (bus.info_o.vld !== 2'b00) begin n_fail++; $display("FAIL dual_empty got %b want 00", bus.info_o.vld); end
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_vld_i  = 1'b1;
            bus.in_addr_i = 8'h10 + 8'(i);
            @(negedge clk);
            n_cmp++; if (bus.in_rdy_o !== (i < 4)) begin n_fail++; $display("FAIL full_rdy_%0d got %b want %b", i, bus.in_rdy_o, (i < 4)); end
            step();
        end
        bus.in_addr_i = 8'hEE; bus.en_i = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL full_rdy_run got %b want 0", bus.in_rdy_o); end
        n_cmp++; if (bus.info_o !== mk(2'b11, 8'h11, 8'h10)) begin n_fail++; $display("FAIL full_head got %h want %h", bus.info_o, mk(2'b11, 8'h11, 8'h10)); end
        bus.info_rdy_i = 1'b1;
        step();
        bus.info_rdy_i = 1'b0; bus.in_vld_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL full_rdy_after_pop got %b want 1", bus.in_rdy_o); end
        n_cmp++; if (bus.info_o !== mk(2'b11, 8'h13, 8'h12)) begin n_fail++; $display("FAIL full_second got %h want %h", bus.info_o, mk(2'b11, 8'h13, 8'h12)); end
        bus.info_rdy_i = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL full_no_bypass got %h want 0", bus.info_o); end
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        bus.in_vld_i = 1'b1; bus.in_addr_i = 8'h3C; step();
        bus.in_vld_i = 1'b0; bus.en_i = 1'b1; bus.info_rdy_i = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== mk(2'b01, 8'h00, 8'h3C)) begin n_fail++; $display("FAIL single_beat got %h want %h", bus.info_o, mk(2'b01, 8'h00, 8'h3C)); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o.vld !== 2'b00) begin n_fail++; $display("FAIL single_empty got %b want 00", bus.info_o.vld); end
        n_cmp++; if (bus.beat_cnt_o !== 4'd1) begin n_fail++; $display("FAIL single_beat_cnt got %0d want 1", bus.beat_cnt_o); end
        idle_inputs();
    endtask

    task automatic test_terminal();
        do_reset();
        bus.en_i = 1'b1; bus.info_rdy_i = 1'b1; bus.in_vld_i = 1'b1; bus.in_addr_i = 8'h00;
        step();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.beat_cnt_o !== 4'(k - 1)) begin n_fail++; $display("FAIL term_cnt_%0d got %0d want %0d", k, bus.beat_cnt_o, k - 1); end
            n_cmp++; if (bus.end_cnt_o !== 1'b0) begin n_fail++; $display("FAIL term_end_early_%0d got %b want 0", k, bus.end_cnt_o); end
            bus.in_addr_i = 8'(k);
            step();
        end
        @(negedge clk);
        n_cmp++; if (bus.end_cnt_o !== 1'b1) begin n_fail++; $display("FAIL term_end got %b want 1", bus.end_cnt_o); end
        n_cmp++; if (bus.beat_cnt_o !== 4'd0) begin n_fail++; $display("FAIL term_cnt_clear got %0d want 0", bus.beat_cnt_o); end
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL term_done_info got %h want 0", bus.info_o); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.end_cnt_o !== 1'b0) begin n_fail++; $display("FAIL term_end_one_cycle got %b want 0", bus.end_cnt_o); end
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL term_idle_info got %h want 0", bus.info_o); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o.vld !== 2'b11) begin n_fail++; $display("FAIL term_rerun got %b want 11", bus.info_o.vld); end
        idle_inputs();
    endtask

    task automatic test_pause();
        do_reset();
        bus.en_i = 1'b1; bus.info_rdy_i = 1'b1; bus.in_vld_i = 1'b1; bus.in_addr_i = 8'h55;
        step();
        for (int k = 0; k < 5; k++) step();
        idle_inputs();
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL pause_info got %h want 0", bus.info_o); end
        n_cmp++; if (bus.beat_cnt_o !== 4'd5) begin n_fail++; $display("FAIL pause_cnt got %0d want 5", bus.beat_cnt_o); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.beat_cnt_o !== 4'd5) begin n_fail++; $display("FAIL pause_hold got %0d want 5", bus.beat_cnt_o); end
        bus.en_i = 1'b1; bus.info_rdy_i = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== mk(2'b01, 8'h00, 8'h55)) begin n_fail++; $display("FAIL pause_kept got %h want %h", bus.info_o, mk(2'b01, 8'h00, 8'h55)); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.beat_cnt_o !== 4'd6) begin n_fail++; $display("FAIL pause_resume got %0d want 6", bus.beat_cnt_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.in_vld_i = 1'b1;
        bus.in_addr_i = 8'h21; step();
        bus.in_addr_i = 8'h22; step();
        bus.in_addr_i = 8'h23; step();
        bus.in_vld_i = 1'b0; bus.en_i = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== mk(2'b11, 8'h22, 8'h21)) begin n_fail++; $display("FAIL mid_head got %h want %h", bus.info_o, mk(2'b11, 8'h22, 8'h21)); end
        bus.info_rdy_i = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.beat_cnt_o !== 4'd1) begin n_fail++; $display("FAIL mid_cnt got %0d want 1", bus.beat_cnt_o); end
        rst = 1'b0; bus.info_rdy_i = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL mid_rst_info got %h want 0", bus.info_o); end
        n_cmp++; if (bus.beat_cnt_o !== 4'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d want 0", bus.beat_cnt_o); end
        n_cmp++; if (bus.in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rdy got %b want 1", bus.in_rdy_o); end
        n_cmp++; if (bus.end_cnt_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_end got %b want 0", bus.end_cnt_o); end
        rst = 1'b1; bus.en_i = 1'b0;
        step();
        bus.en_i = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.info_o !== info_t'(0)) begin n_fail++; $display("FAIL mid_discard got %h want 0", bus.info_o); end
        n_cmp++; if (bus.end_cnt_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_end got %b want 0", bus.end_cnt_o); end
        idle_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle_inputs();
        test_reset();
        test_dual_pop();
        test_full();
        test_single();
        test_terminal();
        test_pause();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
